// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load extension, write-back mux and retire counter
// Flush beats stall; every output is driven straight from a register.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int PC_W   = 30,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_mem,
   input  logic              regwrite_mem,
   input  logic [1:0]        memtoreg_mem,
   input  logic [2:0]        ldtype_mem,
   input  logic [1:0]        byteoff_mem,
   input  logic [DATA_W-1:0] dmout_mem,
   input  logic [DATA_W-1:0] aluout_mem,
   input  logic [REG_AW-1:0] a3_mem,
   input  logic [PC_W-1:0]   pc_mem,
   output logic              valid_wb,
   output logic              regwrite_wb,
   output logic [REG_AW-1:0] a3_wb,
   output logic [DATA_W-1:0] wd_wb,
   output logic [PC_W-1:0]   pc_wb,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic              r_valid;
   logic              r_regwrite;
   logic [REG_AW-1:0] r_a3;
   logic [DATA_W-1:0] r_wd;
   logic [PC_W-1:0]   r_pc;
   logic [CNT_W-1:0]  r_cnt;

   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [DATA_W-1:0] w_load;
   logic [PC_W+1:0]   w_link;
   logic [DATA_W-1:0] w_wd;
   logic              w_regwrite;

   always_comb begin
      w_byte = dmout_mem[7:0];
      case (byteoff_mem)
         2'd1:    w_byte = dmout_mem[15:8];
         2'd2:    w_byte = dmout_mem[23:16];
         2'd3:    w_byte = dmout_mem[31:24];
         default: w_byte = dmout_mem[7:0];
      endcase
      // Half-word select ignores byteoff[0]; misalignment is trapped upstream.
      w_half = byteoff_mem[1] ? dmout_mem[31:16] : dmout_mem[15:0];

      w_load = dmout_mem;
      case (ldtype_mem)
         3'b001:  w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
         3'b010:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
         3'b011:  w_load = {{(DATA_W-16){w_half[15]}}, w_half};
         3'b100:  w_load = {{(DATA_W-16){1'b0}}, w_half};
         default: w_load = dmout_mem;
      endcase

      w_link = {pc_mem + PC_W'(2), 2'b00};

      w_wd = aluout_mem;
      case (memtoreg_mem)
         2'b01:   w_wd = w_load;
         2'b10:   w_wd = DATA_W'(w_link);
         default: w_wd = aluout_mem;
      endcase

      w_regwrite = regwrite_mem & valid_mem & (a3_mem != '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_a3       <= '0;
         r_wd       <= '0;
         r_pc       <= '0;
         r_cnt      <= '0;
      end else if (flush) begin
         r_valid    <= 1'b0;
         r_regwrite <= 1'b0;
         r_a3       <= '0;
         r_wd       <= '0;
         r_pc       <= '0;
      end else if (!stall) begin
         r_valid    <= valid_mem;
         r_regwrite <= w_regwrite;
         r_a3       <= a3_mem;
         r_wd       <= w_wd;
         r_pc       <= pc_mem;
         if (valid_mem)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign valid_wb    = r_valid;
   assign regwrite_wb = r_regwrite;
   assign a3_wb       = r_a3;
   assign wd_wb       = r_wd;
   assign pc_wb       = r_pc;
   assign retire_cnt  = r_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - table-driven bench for mem_wb_stage, plus stall/flush/reset/wrap sequences
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        valid_mem, regwrite_mem;
   logic [1:0]  memtoreg_mem, byteoff_mem;
   logic [2:0]  ldtype_mem;
   logic [31:0] dmout_mem, aluout_mem;
   logic [4:0]  a3_mem;
   logic [29:0] pc_mem;

   logic        valid_wb, regwrite_wb;
   logic [4:0]  a3_wb;
   logic [31:0] wd_wb;
   logic [29:0] pc_wb;
   logic [31:0] retire_cnt;

   logic        v4, rw4;
   logic [4:0]  a34;
   logic [31:0] wd4;
   logic [29:0] pc4;
   logic [3:0]  cnt4;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_cnt;

   always #5 clk = ~clk;

   mem_wb_stage #(.DATA_W(32), .REG_AW(5), .PC_W(30), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_mem(valid_mem), .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
      .ldtype_mem(ldtype_mem), .byteoff_mem(byteoff_mem), .dmout_mem(dmout_mem),
      .aluout_mem(aluout_mem), .a3_mem(a3_mem), .pc_mem(pc_mem),
      .valid_wb(valid_wb), .regwrite_wb(regwrite_wb), .a3_wb(a3_wb),
      .wd_wb(wd_wb), .pc_wb(pc_wb), .retire_cnt(retire_cnt));

   mem_wb_stage #(.DATA_W(32), .REG_AW(5), .PC_W(30), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_mem(valid_mem), .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
      .ldtype_mem(ldtype_mem), .byteoff_mem(byteoff_mem), .dmout_mem(dmout_mem),
      .aluout_mem(aluout_mem), .a3_mem(a3_mem), .pc_mem(pc_mem),
      .valid_wb(v4), .regwrite_wb(rw4), .a3_wb(a34),
      .wd_wb(wd4), .pc_wb(pc4), .retire_cnt(cnt4));

   typedef struct {
      logic        v, rw;
      logic [1:0]  m;
      logic [2:0]  lt;
      logic [1:0]  bo;
      logic [31:0] dm, alu;
      logic [4:0]  a3;
      logic [29:0] pc;
      logic        ev, erw;
      logic [31:0] ewd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic rw, logic [1:0] m, logic [2:0] lt, logic [1:0] bo,
                               logic [31:0] dm, logic [31:0] alu, logic [4:0] a3, logic [29:0] pc,
                               logic ev, logic erw, logic [31:0] ewd);
      vec_t t;
      t.v = v; t.rw = rw; t.m = m; t.lt = lt; t.bo = bo; t.dm = dm; t.alu = alu;
      t.a3 = a3; t.pc = pc; t.ev = ev; t.erw = erw; t.ewd = ewd;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t t);
      valid_mem = t.v; regwrite_mem = t.rw; memtoreg_mem = t.m; ldtype_mem = t.lt;
      byteoff_mem = t.bo; dmout_mem = t.dm; aluout_mem = t.alu; a3_mem = t.a3; pc_mem = t.pc;
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic erw, input logic [4:0] ea3,
                          input logic [31:0] ewd, input logic [29:0] epc);
      chk({tag, "_valid"}, 64'(valid_wb), 64'(ev));
      chk({tag, "_regwrite"}, 64'(regwrite_wb), 64'(erw));
      chk({tag, "_a3"}, 64'(a3_wb), 64'(ea3));
      chk({tag, "_wd"}, 64'(wd_wb), 64'(ewd));
      chk({tag, "_pc"}, 64'(pc_wb), 64'(epc));
      chk({tag, "_cnt"}, 64'(retire_cnt), 64'(exp_cnt));
      chk({tag, "_cnt4"}, 64'(cnt4), 64'(exp_cnt[3:0]));
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(mk(0, 0, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 30'h0, 0, 0, 32'h0));
      exp_cnt = 32'd0;
      repeat (3) tick();
      chk_all("reset", 0, 0, 5'd0, 32'h0, 30'h0);
      reset = 1'b0;
      tick();
      chk_all("idle", 0, 0, 5'd0, 32'h0, 30'h0);

      //                v  rw m      lt    bo    dmout         alu           a3     pc
      vecs.push_back(mk(1, 1, 2'b01, 3'd1, 2'd1, 32'h1234_80FF, 32'hDEAD_BEEF, 5'd8,  30'h100, 1, 1, 32'hFFFF_FF80));
      vecs.push_back(mk(1, 1, 2'b01, 3'd2, 2'd1, 32'h1234_80FF, 32'hDEAD_BEEF, 5'd8,  30'h101, 1, 1, 32'h0000_0080));
      vecs.push_back(mk(1, 1, 2'b01, 3'd3, 2'd2, 32'h1234_80FF, 32'hDEAD_BEEF, 5'd8,  30'h102, 1, 1, 32'h0000_1234));
      vecs.push_back(mk(1, 1, 2'b01, 3'd4, 2'd2, 32'h8000_7FFF, 32'h0,         5'd9,  30'h103, 1, 1, 32'h0000_8000));
      vecs.push_back(mk(1, 1, 2'b01, 3'd3, 2'd3, 32'h8001_0000, 32'h0,         5'd9,  30'h104, 1, 1, 32'hFFFF_8001));
      vecs.push_back(mk(1, 1, 2'b01, 3'd3, 2'd1, 32'h8001_F00D, 32'h0,         5'd9,  30'h105, 1, 1, 32'hFFFF_F00D));
      vecs.push_back(mk(1, 1, 2'b01, 3'd0, 2'd3, 32'hCAFE_BABE, 32'h0,         5'd10, 30'h106, 1, 1, 32'hCAFE_BABE));
      vecs.push_back(mk(1, 1, 2'b01, 3'd7, 2'd1, 32'h0102_0304, 32'h0,         5'd10, 30'h107, 1, 1, 32'h0102_0304));
      vecs.push_back(mk(1, 1, 2'b01, 3'd1, 2'd3, 32'h7F00_0000, 32'h0,         5'd11, 30'h108, 1, 1, 32'h0000_007F));
      vecs.push_back(mk(1, 1, 2'b01, 3'd1, 2'd0, 32'h0000_0080, 32'h0,         5'd11, 30'h109, 1, 1, 32'hFFFF_FF80));
      vecs.push_back(mk(1, 1, 2'b10, 3'd0, 2'd0, 32'h0,         32'h0,         5'd31, 30'hC00, 1, 1, 32'h0000_3008));
      vecs.push_back(mk(1, 1, 2'b10, 3'd0, 2'd0, 32'h0,         32'h0,         5'd0,  30'hC00, 1, 0, 32'h0000_3008));
      vecs.push_back(mk(1, 1, 2'b00, 3'd1, 2'd1, 32'hFFFF_FFFF, 32'h1122_3344, 5'd3,  30'h200, 1, 1, 32'h1122_3344));
      vecs.push_back(mk(1, 1, 2'b11, 3'd1, 2'd1, 32'hFFFF_FFFF, 32'h5566_7788, 5'd4,  30'h201, 1, 1, 32'h5566_7788));
      vecs.push_back(mk(0, 1, 2'b00, 3'd0, 2'd0, 32'h0,         32'hAAAA_0000, 5'd5,  30'h44,  0, 0, 32'hAAAA_0000));
      vecs.push_back(mk(1, 1, 2'b10, 3'd0, 2'd0, 32'h0,         32'h0,         5'd6,  30'h3FFF_FFFF, 1, 1, 32'h0000_0004));
      vecs.push_back(mk(1, 0, 2'b00, 3'd0, 2'd0, 32'h0,         32'h0000_0777, 5'd7,  30'h300, 1, 0, 32'h0000_0777));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         tick();
         if (vecs[i].v) exp_cnt = exp_cnt + 32'd1;
         chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].erw, vecs[i].a3, vecs[i].ewd, vecs[i].pc);
      end

      // Stall holds pre-stall contents while the MEM inputs keep changing.
      drive(mk(1, 1, 2'b00, 3'd0, 2'd0, 32'h0, 32'h1234_5678, 5'd12, 30'h20, 1, 1, 32'h0));
      tick();
      exp_cnt = exp_cnt + 32'd1;
      chk_all("prestall", 1, 1, 5'd12, 32'h1234_5678, 30'h20);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(mk(1, 1, 2'b01, 3'd1, 2'(i), 32'h9999_0000 + 32'(i), 32'h0BAD_0000 + 32'(i),
                  5'(20 + i), 30'(16'h500 + i), 0, 0, 32'h0));
         tick();
         chk_all($sformatf("stall%0d", i), 1, 1, 5'd12, 32'h1234_5678, 30'h20);
      end
      flush = 1'b1;
      tick();
      chk_all("stallflush", 0, 0, 5'd0, 32'h0, 30'h0);
      flush = 1'b0;
      tick();
      chk_all("stallafterflush", 0, 0, 5'd0, 32'h0, 30'h0);
      stall = 1'b0;
      drive(mk(1, 1, 2'b00, 3'd0, 2'd0, 32'h0, 32'h0000_ABCD, 5'd13, 30'h24, 1, 1, 32'h0));
      tick();
      exp_cnt = exp_cnt + 32'd1;
      chk_all("resume", 1, 1, 5'd13, 32'h0000_ABCD, 30'h24);

      // Asynchronous reset asserted mid-cycle while stalled.
      stall = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      exp_cnt = 32'd0;
      chk_all("asyncreset", 0, 0, 5'd0, 32'h0, 30'h0);
      tick();
      #2;
      reset = 1'b0;
      tick();
      chk_all("stalledpostreset", 0, 0, 5'd0, 32'h0, 30'h0);
      stall = 1'b0;
      tick();
      exp_cnt = exp_cnt + 32'd1;
      chk_all("postreset", 1, 1, 5'd13, 32'h0000_ABCD, 30'h24);

      // Retire counter wrap: the CNT_W=4 instance passes 15 -> 0.
      for (int i = 0; i < 17; i++) begin
         drive(mk(1, 1, 2'b00, 3'd0, 2'd0, 32'h0, 32'(i), 5'd1, 30'(i), 1, 1, 32'h0));
         tick();
         exp_cnt = exp_cnt + 32'd1;
         chk($sformatf("wrap%0d_cnt4", i), 64'(cnt4), 64'(exp_cnt[3:0]));
         chk($sformatf("wrap%0d_cnt", i), 64'(retire_cnt), 64'(exp_cnt));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register for the five-stage MIPS core. It supersedes the plain latch with four additions: stall/flush control, a valid bit, load-data extension (lb/lbu/lh/lhu/lw), and a registered write-back data mux. The WB stage therefore receives a single final write-data word. It also keeps a retired-instruction counter for CPI measurement.

Parameters:
DATA_W, 32, datapath width (dmout, aluout, write-back data)
REG_AW, 5, register-file address width
PC_W, 30, PC width in words (pc[31:2])
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold current WB contents
flush  in  1  load a bubble; overrides stall
valid_mem  in  1  MEM stage holds a real instruction
regwrite_mem  in  1  instruction writes the register file
memtoreg_mem  in  2  write-back source select: 00 ALU, 01 load, 10 link (PC+8), 11 ALU
ldtype_mem  in  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others lw
byteoff_mem  in  2  address bits [1:0] of the load
dmout_mem  in  DATA_W  raw data-memory word
aluout_mem  in  DATA_W  ALU result
a3_mem  in  REG_AW  destination register
pc_mem  in  PC_W  instruction PC (word address)
valid_wb  out  1  WB holds a real instruction
regwrite_wb  out  1  qualified register-file write enable
a3_wb  out  REG_AW  destination register
wd_wb  out  DATA_W  final write-back data
pc_wb  out  PC_W  instruction PC
retire_cnt  out  CNT_W  count of instructions entered into WB

Behaviour:
- Reset (async, active-high): every output register goes to 0, including retire_cnt. Reset clears immediately and is independent of clk, stall and flush.
- Rising edge, priority order: reset > flush > stall > capture.
- Flush: valid_wb=0, regwrite_wb=0, a3_wb=0, wd_wb=0, pc_wb=0; retire_cnt unchanged.
- Stall (flush=0): all outputs hold; retire_cnt unchanged.
- Capture:
  - valid_wb<=valid_mem
  - regwrite_wb<=regwrite_mem & valid_mem & (a3_mem!=0)
  - a3_wb<=a3_mem; pc_wb<=pc_mem; wd_wb<=selected data (below)
  - retire_cnt<=retire_cnt+1 when valid_mem=1. The counter wraps modulo 2^CNT_W; no saturation.
- Latency: one cycle from MEM inputs to WB outputs. All outputs come straight from registers; there is no combinational path from input to output.
- Load extension (memtoreg_mem=01), computed before the register:
  - lw: dmout_mem unchanged; byteoff ignored.
  - lb/lbu: byte = dmout_mem[8*byteoff+7 : 8*byteoff]; sign-extend for lb, zero-extend for lbu.
  - lh/lhu: half = byteoff[1] ? dmout_mem[31:16] : dmout_mem[15:0]; sign-extend for lh, zero-extend for lhu. byteoff[0] is ignored; alignment is the MEM stage's job.
  - Undefined ldtype codes behave as lw.
- Link (memtoreg_mem=10): wd = {pc_mem+2, 2'b00}, i.e. PC+8. The PC_W-bit addition wraps.
- Width rule: DATA_W must equal PC_W+2 whenever link is used. Extension fills bits DATA_W-1 down to 8 (byte) or 16 (half).
- A bubble (valid_mem=0) still latches a3/pc/wd, but regwrite_wb is forced to 0.
- stall and flush together: flush wins, and a bubble is inserted.
- Reset asserted mid-stall: outputs clear at once. After release, capture resumes on the first edge where stall=0.

Test Plan:
- Reset 3 cycles then release, all inputs 0 -> every output 0, retire_cnt=0. Assert reset mid-run -> outputs 0 before the next edge.
- Capture lb: dmout=0x1234_80FF, byteoff=1, ldtype=001, memtoreg=01, a3=8, valid=1, regwrite=1 -> next cycle wd_wb=0xFFFF_FF80, regwrite_wb=1, retire_cnt=1. Repeat with lbu -> 0x0000_0080. Repeat with lh, byteoff=2 -> 0x0000_1234.
- Link: memtoreg=10, pc_mem=0x0000_0C00 (byte 0x3000), a3=31 -> wd_wb=0x0000_3008. Also a3=0, regwrite=1 -> regwrite_wb=0.
- Stall 3 cycles while inputs change -> outputs hold the pre-stall values and retire_cnt is unchanged. stall=1 with flush=1 -> valid_wb=0, regwrite_wb=0.
- Bubble: valid_mem=0, regwrite_mem=1 -> regwrite_wb=0, valid_wb=0, retire_cnt unchanged.
- Counter wrap with CNT_W=4: 16 valid captures -> retire_cnt goes 15 -> 0.
